// File: rtl/exec_pkg.sv
`default_nettype none
// exec_pkg: shared encodings and EX/MEM buffer layout for the multi-cycle execute stage.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_SUB   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_CMP   = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_MUL   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Control/flag bits sit right above ra, relative to off_ctl().
  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_BRANCH     = 3;
  localparam int CTL_NEG        = 4;
  localparam int CTL_ZERO       = 5;
  localparam int OP_TYPE_W      = 2;

  function automatic int off_rd3();                     return 0;                    endfunction
  function automatic int off_rc (int n);                return n;                    endfunction
  function automatic int off_rb (int n, int rw);        return n + rw;               endfunction
  function automatic int off_ra (int n, int rw);        return n + 2*rw;             endfunction
  function automatic int off_ctl(int n, int rw);        return n + 3*rw;             endfunction
  function automatic int off_alu(int n, int rw);        return n + 3*rw + 6;         endfunction
  function automatic int off_opc(int n, int rw);        return 2*n + 3*rw + 6;       endfunction
  function automatic int off_opt(int n, int rw, int w); return 2*n + 3*rw + 6 + w;   endfunction
  function automatic int buf_width(int n, int rw, int w); return 2*n + 3*rw + w + 8; endfunction

endpackage
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// exec_mul_iter: N-cycle shift-add multiplier keeping the low N bits of a*b.
module exec_mul_iter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (en) begin
      if (clear) begin
        cnt <= '0;
      end else if (start) begin
        cnt    <= CW'(N);
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

  assign busy    = (cnt != '0);
  // done flags the final iteration: product is complete after this edge.
  assign done    = (cnt == CW'(1));
  assign product = acc;

endmodule
`default_nettype wire

// File: rtl/exec_stage_mc.sv
`default_nettype none
// exec_stage_mc: execute stage with forwarding muxes, single-cycle ALU, iterative MUL
// and a valid/ready EX/MEM output register.
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int RW  = 4,
  parameter  int OPW = 2,
  localparam int BW  = buf_width(N, RW, OPW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   rd1,
  input  logic [N-1:0]   rd2,
  input  logic [N-1:0]   rd3,
  input  logic [N-1:0]   pc,
  input  logic [N-1:0]   imm,
  input  logic [N-1:0]   fwd_mem,
  input  logic [N-1:0]   fwd_wb,
  input  logic [1:0]     fa,
  input  logic [1:0]     fb,
  input  logic           imm_src,
  input  logic           branch_flag,
  input  logic [3:0]     alu_control,
  input  logic [RW-1:0]  ra,
  input  logic [RW-1:0]  rb,
  input  logic [RW-1:0]  rc,
  input  logic           reg_write,
  input  logic           mem_to_reg,
  input  logic           mem_write,
  input  logic [1:0]     op_type,
  input  logic [OPW-1:0] op_code,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BW-1:0]  buffer_out
);

  localparam int SW    = $clog2(N);
  localparam int O_RD3 = off_rd3();
  localparam int O_RC  = off_rc(N);
  localparam int O_RB  = off_rb(N, RW);
  localparam int O_RA  = off_ra(N, RW);
  localparam int O_CTL = off_ctl(N, RW);
  localparam int O_ALU = off_alu(N, RW);
  localparam int O_OPC = off_opc(N, RW);
  localparam int O_OPT = off_opt(N, RW, OPW);

  logic [N-1:0]  a_fwd, b_fwd, op_a, op_b, alu_y, mul_product;
  logic [SW-1:0] shamt;
  logic [BW-1:0] in_word, held;
  logic          slot_free, is_mul, accept, mul_start, done_load, mul_busy, mul_done;
  state_e        state, state_nx;

  always_comb begin
    case (fa)
      FWD_MEM: a_fwd = fwd_mem;
      FWD_WB:  a_fwd = fwd_wb;
      default: a_fwd = rd1;
    endcase
    case (fb)
      FWD_MEM: b_fwd = fwd_mem;
      FWD_WB:  b_fwd = fwd_wb;
      default: b_fwd = rd2;
    endcase
  end

  assign op_a  = branch_flag ? pc  : a_fwd;
  assign op_b  = imm_src     ? imm : b_fwd;
  assign shamt = op_b[SW-1:0];

  // MUL is produced by the iterative unit; the combinational path yields 0 for it.
  always_comb begin
    alu_y = '0;
    case (alu_control)
      ALU_SUB, ALU_CMP: alu_y = op_a - op_b;
      ALU_ADD:          alu_y = op_a + op_b;
      ALU_AND:          alu_y = op_a & op_b;
      ALU_OR:           alu_y = op_a | op_b;
      ALU_XOR:          alu_y = op_a ^ op_b;
      ALU_SLL:          alu_y = op_a << shamt;
      ALU_SRL:          alu_y = op_a >> shamt;
      ALU_SRA:          alu_y = $signed(op_a) >>> shamt;
      ALU_PASSB:        alu_y = op_b;
      default:          alu_y = '0;
    endcase
  end

  always_comb begin
    in_word                        = '0;
    in_word[O_RD3 +: N]            = rd3;
    in_word[O_RC  +: RW]           = rc;
    in_word[O_RB  +: RW]           = rb;
    in_word[O_RA  +: RW]           = ra;
    in_word[O_CTL+CTL_REG_WRITE]   = reg_write;
    in_word[O_CTL+CTL_MEM_TO_REG]  = mem_to_reg;
    in_word[O_CTL+CTL_MEM_WRITE]   = mem_write;
    in_word[O_CTL+CTL_BRANCH]      = branch_flag;
    in_word[O_OPC +: OPW]          = op_code;
    in_word[O_OPT +: OP_TYPE_W]    = op_type;
  end

  function automatic logic [BW-1:0] with_result(input logic [BW-1:0] base, input logic [N-1:0] y);
    logic [BW-1:0] w;
    w                   = base;
    w[O_ALU +: N]       = y;
    w[O_CTL+CTL_ZERO]   = (y == '0);
    w[O_CTL+CTL_NEG]    = y[N-1];
    return w;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign is_mul    = (alu_control == ALU_MUL);

  always_comb begin
    state_nx  = state;
    in_ready  = en && (state == ST_IDLE) && slot_free;
    accept    = in_valid && in_ready && !flush;
    mul_start = 1'b0;
    done_load = 1'b0;
    if (en) begin
      if (flush) begin
        state_nx = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (accept && is_mul) begin
            state_nx  = ST_MUL;
            mul_start = 1'b1;
          end
          ST_MUL: begin
            if (!mul_busy)     state_nx = ST_IDLE;
            else if (mul_done) state_nx = ST_DONE;
          end
          ST_DONE: if (slot_free) begin
            state_nx  = ST_IDLE;
            done_load = 1'b1;
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  exec_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clear   (flush),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Flush drops the slot but leaves buffer_out as it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      buffer_out <= '0;
      held       <= '0;
    end else if (en && flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      if (accept && !is_mul) begin
        buffer_out <= with_result(in_word, alu_y);
        out_valid  <= 1'b1;
      end else if (done_load) begin
        buffer_out <= with_result(held, mul_product);
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (mul_start) held <= in_word;
    end
  end

endmodule
`default_nettype wire
